// File: rtl/axi_burst_pkg.sv
// Shared types, AXI response codes and helper functions for axi_burst_master.
//   state_t      - burst master FSM states
//   RESP_*       - AXI BRESP/RRESP encodings (numerically ordered by severity)
//   BURST_INCR   - AxBURST encoding for incrementing bursts
//   axsize()     - AxSIZE for a given data width
//   crosses_4k() - true when a burst would run past the end of its 4 KB page
//   worst_resp() - more severe of two responses
package axi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AW     = 3'd1,
    ST_WDATA  = 3'd2,
    ST_BRESP  = 3'd3,
    ST_AR     = 3'd4,
    ST_RDATA  = 3'd5,
    ST_REJECT = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  // AxSIZE is log2 of the bytes per beat.
  function automatic logic [2:0] axsize(input int unsigned data_w);
    return 3'($clog2(data_w / 32'd8));
  endfunction

  // A burst covers (len+1)*strb_w bytes starting at the page offset addr_lo;
  // landing exactly on the page end is still legal.
  function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                      input int unsigned len,
                                      input int unsigned strb_w);
    int unsigned span;
    span = 32'(addr_lo) + (len + 32'd1) * strb_w;
    return (span > 32'd4096);
  endfunction

  // Response encodings grow with severity, so the worst one is the larger.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 single-burst master behind the user start/free/stall handshake.
// Issues one INCR write or read burst of 1..2^LEN_W beats per accepted start,
// rejecting misaligned or 4 KB-crossing requests without any AXI traffic.
// Ports:
//   aclk, areset              clock, synchronous active-high reset
//   user_start/w_r/addr_in/burst_len_in   request (sampled while user_free)
//   user_data_in/user_data_strb           write beat, passed to WDATA/WSTRB
//   user_data_out/_en                     registered read beat + 1-cycle strobe
//   user_free/stall_w_data/stall_r_data   flow-control back to the user
//   user_status/user_error                worst response, sticky error
//   m_axi_aw*/w*/b*/ar*/r*                AXI4 master channels
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  user_start,
  input  logic                  user_w_r,
  input  logic [ADDR_W-1:0]     user_addr_in,
  input  logic [LEN_W-1:0]      user_burst_len_in,
  input  logic [DATA_W-1:0]     user_data_in,
  input  logic [DATA_W/8-1:0]   user_data_strb,
  output logic [DATA_W-1:0]     user_data_out,
  output logic                  user_data_out_en,
  output logic                  user_free,
  output logic                  user_stall_w_data,
  output logic                  user_stall_r_data,
  output logic [1:0]            user_status,
  output logic                  user_error,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W:0]      r_cnt;        // one extra bit so a full-length burst never wraps
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_out_en;
  logic [1:0]          r_status;
  logic                r_error;

  logic                w_awvalid;
  logic                w_wvalid;
  logic                w_bready;
  logic                w_arvalid;
  logic                w_rready;
  logic                w_misaligned;
  logic                w_reject;
  logic                w_cnt_at_len;
  logic                w_w_hs;
  logic                w_r_hs;

  assign w_misaligned = ((user_addr_in & ADDR_W'(STRB_W - 1)) != '0);
  assign w_reject     = w_misaligned |
                        crosses_4k(user_addr_in[11:0], 32'(user_burst_len_in), 32'(STRB_W));
  assign w_cnt_at_len = (r_cnt == {1'b0, r_len});
  assign w_w_hs       = w_wvalid & m_axi_wready;
  assign w_r_hs       = w_rready & m_axi_rvalid;

  // FSM state register
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and channel valid/ready decode
  always_comb begin
    w_next    = r_state;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (user_start) begin
          if (w_reject) begin
            w_next = ST_REJECT;
          end else if (user_w_r) begin
            w_next = ST_AR;
          end else begin
            w_next = ST_AW;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_AW: begin
        w_awvalid = 1'b1;
        if (m_axi_awready) w_next = ST_WDATA;
        else               w_next = ST_AW;
      end
      ST_WDATA: begin
        w_wvalid = 1'b1;
        if (m_axi_wready && w_cnt_at_len) w_next = ST_BRESP;
        else                              w_next = ST_WDATA;
      end
      ST_BRESP: begin
        w_bready = 1'b1;
        if (m_axi_bvalid) w_next = ST_IDLE;
        else              w_next = ST_BRESP;
      end
      ST_AR: begin
        w_arvalid = 1'b1;
        if (m_axi_arready) w_next = ST_RDATA;
        else               w_next = ST_AR;
      end
      ST_RDATA: begin
        w_rready = 1'b1;
        // Only RLAST ends a read; a short or long burst is flagged, not cut.
        if (m_axi_rvalid && m_axi_rlast) w_next = ST_IDLE;
        else                             w_next = ST_RDATA;
      end
      ST_REJECT: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request capture, beat counter, read data and status/error tracking
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_data_out    <= '0;
      r_data_out_en <= 1'b0;
      r_status      <= RESP_OKAY;
      r_error       <= 1'b0;
    end else begin
      r_data_out_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (user_start) begin
            r_addr   <= user_addr_in;
            r_len    <= user_burst_len_in;
            r_status <= w_reject ? RESP_SLVERR : RESP_OKAY;
            r_error  <= w_reject;
          end
        end
        ST_AW: begin
          if (m_axi_awready) r_cnt <= '0;
        end
        ST_AR: begin
          if (m_axi_arready) r_cnt <= '0;
        end
        ST_WDATA: begin
          if (w_w_hs) r_cnt <= r_cnt + {{LEN_W{1'b0}}, 1'b1};
        end
        ST_BRESP: begin
          if (m_axi_bvalid) r_status <= worst_resp(r_status, m_axi_bresp);
        end
        ST_RDATA: begin
          if (w_r_hs) begin
            r_data_out    <= m_axi_rdata;
            r_data_out_en <= 1'b1;
            r_status      <= worst_resp(r_status, m_axi_rresp);
            r_cnt         <= r_cnt + {{LEN_W{1'b0}}, 1'b1};
            // Early RLAST, or the expected last beat arriving without RLAST.
            if (m_axi_rlast != w_cnt_at_len) r_error <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign user_data_out     = r_data_out;
  assign user_data_out_en  = r_data_out_en;
  assign user_free         = (r_state == ST_IDLE);
  assign user_stall_w_data = ~w_w_hs;
  assign user_stall_r_data = ~w_rready;
  assign user_status       = r_status;
  assign user_error        = r_error;

  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 8'(r_len);
  assign m_axi_awsize  = axsize(32'(DATA_W));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awvalid = w_awvalid;

  // Write data is driven only while W is open so it reads zero otherwise.
  assign m_axi_wdata   = w_wvalid ? user_data_in : '0;
  assign m_axi_wstrb   = w_wvalid ? user_data_strb : '0;
  assign m_axi_wlast   = w_wvalid & w_cnt_at_len;
  assign m_axi_wvalid  = w_wvalid;
  assign m_axi_bready  = w_bready;

  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = 8'(r_len);
  assign m_axi_arsize  = axsize(32'(DATA_W));
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = w_arvalid;
  assign m_axi_rready  = w_rready;

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Parametrised AXI4 burst master behind the user start/free/stall handshake used by our traffic generator. It issues single INCR write or read bursts of 1 to 2^LEN_W beats at any DATA_W. It adds three things the previous generation lacked: 4 KB-boundary and alignment rejection, worst-case response reporting, and RLAST consistency checking. It sits between the user-side stimulus logic and an AXI slave (VIP memory model in simulation).

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width; power of two, 8..1024; STRB_W = DATA_W/8
- LEN_W, 8, burst-length field width; max burst = 2^LEN_W beats, LEN_W ≤ 8
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous reset, active-high
- user_start  in  1  request strobe, sampled only while user_free=1
- user_w_r  in  1  0 = write, 1 = read; sampled with user_start
- user_addr_in  in  ADDR_W  burst start byte address
- user_burst_len_in  in  LEN_W  beats−1
- user_data_in  in  DATA_W  current write beat; passed through to WDATA
- user_data_strb  in  STRB_W  current write-beat strobe; passed through to WSTRB
- user_data_out  out  DATA_W  registered read beat
- user_data_out_en  out  1  one-cycle strobe per valid user_data_out
- user_free  out  1  high in IDLE only
- user_stall_w_data  out  1  low in the cycle the current write beat is accepted
- user_stall_r_data  out  1  low while in RDATA
- user_status  out  2  worst BRESP/RRESP of the last burst (OKAY<EXOKAY<SLVERR<DECERR)
- user_error  out  1  sticky until next accepted start: rejected request or RLAST mismatch
- m_axi_awaddr/awlen/awsize/awburst/awvalid  out  ADDR_W/8/3/2/1  write address
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wlast/wvalid  out  DATA_W/STRB_W/1/1
- m_axi_wready  in  1
- m_axi_bresp/bvalid  in  2/1
- m_axi_bready  out  1
- m_axi_araddr/arlen/arsize/arburst/arvalid  out  ADDR_W/8/3/2/1
- m_axi_arready  in  1
- m_axi_rdata/rresp/rlast/rvalid  in  DATA_W/2/1/1
- m_axi_rready  out  1

## Operation
- States: IDLE, AW, WDATA, BRESP, AR, RDATA, REJECT.
- IDLE → capture addr/len/w_r on user_start. Clear user_status and user_error on capture.
- Reject check runs at capture: addr not STRB_W-aligned, or addr[11:0] + (len+1)·STRB_W > 4096. On reject → REJECT (1 cycle, user_error=1, user_status=2'b10, no AXI traffic) → IDLE.
- Write path: IDLE → AW, hold awvalid until awready → WDATA. wvalid=1; WDATA/WSTRB are combinational from user inputs.
  - A beat is accepted on wvalid&wready. user_stall_w_data = !(wvalid&wready).
  - wlast=1 when beat counter == len. The last accepted beat → BRESP.
  - bready=1 in BRESP. On bvalid: fold bresp into status → IDLE.
- Read path: IDLE → AR, hold arvalid until arready → RDATA. rready=1.
  - On each rvalid: register rdata into user_data_out, pulse user_data_out_en next cycle, fold rresp into status.
  - rlast with counter≠len sets user_error and ends the burst. Counter==len without rlast sets user_error, and the burst ends only on rlast.
- AxSIZE = log2(STRB_W), AxBURST = INCR (2'b01). AxLEN = zero-extended len.
- Beat counter is LEN_W+1 bits and resets to 0 on entering WDATA/RDATA, so 256-beat bursts have no wrap.
- user_start while busy is ignored; no queueing.

## Timing
- Reset values:
  - state IDLE, user_free=1, user_stall_w_data=1, user_stall_r_data=1.
  - All AXI valid/ready/last outputs 0. Address/len/data outputs 0, AxSIZE/AxBURST constant.
  - user_data_out=0, user_data_out_en=0, user_status=00, user_error=0.
- Start sampled on edge T → awvalid/arvalid high from T+1. Address handshake at A → wvalid/rready high from A+1.
- Write throughput: 1 beat/cycle with wready held high. user_free returns the cycle after the B handshake.
- Read latency: rdata beat at edge R appears on user_data_out with user_data_out_en high during R+1. user_free returns the cycle after the rlast handshake.
- areset mid-burst: IDLE next edge, all valids drop immediately. The bench must reset the slave as well.
- awvalid/arvalid are never deasserted before their ready; W is never issued before the AW handshake.

## Structure
- Package axi_burst_pkg:
  - state enum
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - BURST_INCR
  - function axsize(DATA_W)
  - function crosses_4k(addr, len, STRB_W)
  - function worst_resp(a, b)
- Single module, no sub-module; the FSM and counter are small enough to stay inline.

## Test plan
- Write 1 beat to 0x1000_0000 (DATA_W=64, len=0), read back → AWLEN=0, WLAST on beat 0, user_data_out = written data, user_status=00.
- Write then read 16 beats at 0x1000_0080 (len=15) with random wready/rvalid gaps → 16 stall-low cycles, 16 data_out_en pulses, data equal.
- len=255 at 0x2000_0000, DATA_W=32 → 256 beats, WLAST only on beat 255, no counter wrap.
- Request at 0x1000_0FC0, len=15, DATA_W=64 (crosses 4 KB) → no AWVALID, user_error=1, status=10, user_free back after 2 cycles.
- Slave returns SLVERR on beat 3 of 8 read, RLAST on beat 6 → user_status=10, user_error=1, FSM in IDLE.
- areset pulsed during WDATA beat 5 → all valids 0 next cycle. A following 4-beat write completes normally.
